// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the in-order pipeline hazard/stall controller.
package pipe_ctrl_pkg;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    // addi x0,x0,0: what a flushed or bubbled stage register holds
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DISCARD  = 2'd2
    } pipe_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Stage-status inputs and stage-register control outputs of the pipeline controller.
interface pipeline_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [4:0]       ex_rd;
    logic             ex_mem_read;
    logic             ex_redirect;
    logic             imem_valid;
    logic             mem_busy;
    logic             dmem_ready;
    logic             pc_we;
    logic             if_id_we;
    logic             id_ex_we;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             pc_sel_redirect;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] redirect_cnt;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               ex_redirect, imem_valid, mem_busy, dmem_ready,
        input  pc_we, if_id_we, id_ex_we, if_id_flush, id_ex_bubble,
               pc_sel_redirect, stall_cnt, redirect_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               ex_redirect, imem_valid, mem_busy, dmem_ready,
        output pc_we, if_id_we, id_ex_we, if_id_flush, id_ex_bubble,
               pc_sel_redirect, stall_cnt, redirect_cnt
    );

endinterface

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the instruction in ID and a load in EX.
module hazard_detect (
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    output logic       hazard
);

    logic rs1_match_s;
    logic rs2_match_s;

    // x0 is hardwired zero, so a load targeting it never produces a dependency
    assign rs1_match_s = id_use_rs1 && (id_rs1 == ex_rd);
    assign rs2_match_s = id_use_rs2 && (id_rs2 == ex_rd);
    assign hazard      = ex_mem_read && (ex_rd != 5'd0) && (rs1_match_s || rs2_match_s);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: MEM wait > redirect > load-use > fetch wait,
// plus saturating stall and redirect performance counters.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    pipeline_ctrl_if.slave bus
);

    pipe_state_e      state_r;
    pipe_state_e      next_s;
    logic             hazard_s;
    logic             mem_wait_s;
    logic             pc_we_s;
    logic             if_id_we_s;
    logic             id_ex_we_s;
    logic             flush_s;
    logic             bubble_s;
    logic             sel_s;
    logic             redirect_evt_s;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] redirect_cnt_r;

    hazard_detect u_hazard (
        .id_rs1      (bus.id_rs1),
        .id_rs2      (bus.id_rs2),
        .id_use_rs1  (bus.id_use_rs1),
        .id_use_rs2  (bus.id_use_rs2),
        .ex_rd       (bus.ex_rd),
        .ex_mem_read (bus.ex_mem_read),
        .hazard      (hazard_s)
    );

    assign mem_wait_s = bus.mem_busy && !bus.dmem_ready;

    // Next-state and stage-control decode; a completing MEM_WAIT falls through to RUN rules
    always_comb begin
        next_s         = state_r;
        pc_we_s        = 1'b1;
        if_id_we_s     = 1'b1;
        id_ex_we_s     = 1'b1;
        flush_s        = 1'b0;
        bubble_s       = 1'b0;
        sel_s          = 1'b0;
        redirect_evt_s = 1'b0;
        if (!reset) begin
            pc_we_s    = 1'b0;
            if_id_we_s = 1'b0;
            flush_s    = 1'b1;
            bubble_s   = 1'b1;
            next_s     = RUN;
        end else if (mem_wait_s) begin
            pc_we_s    = 1'b0;
            if_id_we_s = 1'b0;
            id_ex_we_s = 1'b0;
            next_s     = MEM_WAIT;
        end else begin
            case (state_r)
                RUN, MEM_WAIT: begin
                    if (bus.ex_redirect) begin
                        sel_s          = 1'b1;
                        flush_s        = 1'b1;
                        bubble_s       = 1'b1;
                        redirect_evt_s = 1'b1;
                        next_s         = DISCARD;
                    end else if (hazard_s) begin
                        pc_we_s    = 1'b0;
                        if_id_we_s = 1'b0;
                        bubble_s   = 1'b1;
                        next_s     = RUN;
                    end else if (!bus.imem_valid) begin
                        pc_we_s    = 1'b0;
                        if_id_we_s = 1'b0;
                        bubble_s   = 1'b1;
                        next_s     = RUN;
                    end else begin
                        next_s = RUN;
                    end
                end
                DISCARD: begin
                    // the first fetch returned after a redirect is wrong-path and is dropped
                    if (bus.ex_redirect) begin
                        sel_s          = 1'b1;
                        flush_s        = 1'b1;
                        bubble_s       = 1'b1;
                        redirect_evt_s = 1'b1;
                        next_s         = DISCARD;
                    end else if (bus.imem_valid) begin
                        flush_s = 1'b1;
                        next_s  = RUN;
                    end else begin
                        pc_we_s    = 1'b0;
                        if_id_we_s = 1'b0;
                        bubble_s   = 1'b1;
                        next_s     = DISCARD;
                    end
                end
                default: begin
                    pc_we_s    = 1'b0;
                    if_id_we_s = 1'b0;
                    flush_s    = 1'b1;
                    bubble_s   = 1'b1;
                    next_s     = RUN;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= RUN;
        end else begin
            state_r <= next_s;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_r    <= {CNT_W{1'b0}};
            redirect_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (!pc_we_s) begin
                stall_cnt_r <= sat_inc(stall_cnt_r);
            end
            if (redirect_evt_s) begin
                redirect_cnt_r <= sat_inc(redirect_cnt_r);
            end
        end
    end

    assign bus.pc_we           = pc_we_s;
    assign bus.if_id_we        = if_id_we_s;
    assign bus.id_ex_we        = id_ex_we_s;
    assign bus.if_id_flush     = flush_s;
    assign bus.id_ex_bubble    = bubble_s;
    assign bus.pc_sel_redirect = sel_s;
    assign bus.stall_cnt       = stall_cnt_r;
    assign bus.redirect_cnt    = redirect_cnt_r;

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1: synchronous, active-low reset (0 = reset, sampled on rising clk).
REQ-003 SHALL have port id_rs1 / id_rs2, input, 5 each: source register indices of instruction in ID.
REQ-004 SHALL have port id_use_rs1 / id_use_rs2, input, 1 each: ID instruction actually reads that source.
REQ-005 SHALL have port ex_rd, input, 5, and ex_mem_read, input, 1: destination and load flag of instruction in EX.
REQ-006 SHALL have port ex_redirect, input, 1: taken branch, jal or jalr resolved in EX this cycle.
REQ-007 SHALL have port imem_valid, input, 1: fetch response valid this cycle.
REQ-008 SHALL have ports mem_busy, input, 1 (MEM stage holds a load/store) and dmem_ready, input, 1 (that access completes this cycle).
REQ-009 SHALL have outputs pc_we, if_id_we, id_ex_we, 1 each: stage register enables.
REQ-010 SHALL have outputs if_id_flush and id_ex_bubble, 1 each: insert addi x0,x0,0 into that register.
REQ-011 SHALL have output pc_sel_redirect, 1: PC mux selects EX target.
REQ-012 SHALL have outputs stall_cnt, 16, and redirect_cnt, 16: saturating performance counters.

Function
REQ-013 SHALL implement FSM states RUN, MEM_WAIT, DISCARD; control outputs are combinational from state plus inputs.
REQ-014 SHALL apply priority per cycle: MEM wait > redirect > load-use > fetch wait.
REQ-015 MEM wait: mem_busy=1 and dmem_ready=0 -> all enables 0, no flush/bubble, enter/stay MEM_WAIT; in MEM_WAIT, ex_redirect and load-use are ignored.
REQ-016 MEM_WAIT exit: dmem_ready=1 -> the same cycle evaluated with RUN rules; next state per those rules.
REQ-017 Redirect (RUN, no MEM wait): pc_sel_redirect=1, pc_we=1, if_id_flush=1, id_ex_bubble=1, id_ex_we=1; next state DISCARD.
REQ-018 DISCARD: first imem_valid=1 cycle is dropped (if_id_flush=1, pc_we=1), then return RUN; while imem_valid=0: pc_we=0, if_id_we=0, id_ex_bubble=1.
REQ-019 A second ex_redirect in DISCARD SHALL be honoured per REQ-017 and stay in DISCARD.
REQ-020 Load-use: ex_mem_read=1, ex_rd!=0, and (id_use_rs1 and id_rs1==ex_rd, or id_use_rs2 and id_rs2==ex_rd) -> pc_we=0, if_id_we=0, id_ex_bubble=1, id_ex_we=1, for exactly that cycle.
REQ-021 ex_rd=0 SHALL never create a hazard.
REQ-022 Fetch wait (RUN, imem_valid=0, no other event): pc_we=0, if_id_we=0, id_ex_bubble=1.
REQ-023 Normal RUN: pc_we=if_id_we=id_ex_we=1, all others 0.
REQ-024 stall_cnt SHALL increment once per cycle with pc_we=0 (not in reset); redirect_cnt once per REQ-017 event; both saturate at 16'hFFFF.

Reset
REQ-025 reset=0 at a rising edge SHALL force state RUN and both counters to 0, aborting MEM_WAIT/DISCARD.
REQ-026 While reset=0, outputs SHALL be pc_we=0, if_id_we=0, id_ex_we=1, id_ex_bubble=1, if_id_flush=1, pc_sel_redirect=0.

Structure
REQ-027 Shared package pipe_ctrl_pkg SHALL hold the state enum, CNT_W=16, and the NOP encoding 32'h0000_0013.
REQ-028 Load-use compare SHALL be a combinational sub-module hazard_detect; FSM and counters remain in pipeline_ctrl.

Verification
REQ-029 ex_mem_read=1, ex_rd=5, id_rs2=5, id_use_rs2=1 -> one cycle pc_we=0, id_ex_bubble=1; stall_cnt 0->1.
REQ-030 Same as REQ-029 with ex_rd=0 -> pc_we=1, no bubble, stall_cnt unchanged.
REQ-031 ex_redirect=1 in RUN, imem_valid=0 for 2 cycles then 1 -> redirect cycle flush+bubble, 2 cycles pc_we=0, third cycle flush, then RUN; redirect_cnt=1.
REQ-032 mem_busy=1, dmem_ready=0 for 3 cycles with ex_redirect=1 held -> enables 0 for 3 cycles; redirect taken on dmem_ready=1 cycle.
REQ-033 reset=0 mid-DISCARD -> next cycle state RUN, counters 0, outputs per REQ-026.
REQ-034 Force stall_cnt to 16'hFFFF, apply a stall -> stays 16'hFFFF.
